button_conditioner: RTL and testbench
=====================================

# button_conditioner

Conditions a raw, bouncing push-button input into clean, single-clock-domain control signals for the LED demo blocks. Sits directly upstream of the LED counter/divider stages and drives their reset and control inputs. Provides a debounced level, one-cycle press and release pulses, and short-click versus long-press classification.

## Interface
- STABLE_CYCLES, 32'd1000000: consecutive clk cycles the synchronized input must differ from the debounced level before the level flips. Legal range is ≥ 2.
- LONG_CYCLES, 32'd100000000: clk cycles held, counted from the press edge, before a press is classified as long. Legal range is ≥ 2.
- clk  input  1  system clock (50 MHz on board).
- rst  input  1  asynchronous, active-low reset. Low means reset. Assertion is asynchronous; deassertion is sampled on clk.
- btn_in  input  1  raw button, active high, asynchronous to clk.
- btn_level  output  1  debounced button level.
- press_pulse  output  1  one-cycle pulse when btn_level rises.
- release_pulse  output  1  one-cycle pulse when btn_level falls.
- short_click  output  1  one-cycle pulse when a release ends a press shorter than LONG_CYCLES.
- long_pulse  output  1  one-cycle pulse when a press reaches LONG_CYCLES.
- long_hold  output  1  high from long_pulse until the release of that press.

## Operation
- Synchronizer: two flops, s1 then s2. Both reset to 0. Only s2 is used downstream.
- Debounce counter: 32-bit register deb_cnt.
  - While s2 == btn_level: deb_cnt is cleared to 0.
  - While s2 != btn_level and deb_cnt < STABLE_CYCLES-1: deb_cnt increments.
  - When s2 != btn_level and deb_cnt == STABLE_CYCLES-1: btn_level toggles and deb_cnt clears.
  - Any bounce back to the old level restarts the count from 0.
- FSM states:
  - RELEASED (reset state). On the debounced rise: press_pulse=1, hold_cnt cleared to 0, go to PRESSED.
  - PRESSED. hold_cnt increments every cycle.
    - On the debounced fall: release_pulse=1 and short_click=1, go to RELEASED.
    - Otherwise, when hold_cnt == LONG_CYCLES-1: long_pulse=1, go to LONG_HELD.
  - LONG_HELD. long_hold=1. On the debounced fall: release_pulse=1, go to RELEASED. No short_click is issued.
- hold_cnt is a 32-bit register and saturates. It never wraps.
- All outputs are registered, with no combinational path from btn_in.
- Reset values:
  - All outputs are 0.
  - s1, s2, deb_cnt and hold_cnt are 0.
  - State is RELEASED.
- Simultaneous events:
  - If the debounced fall and hold_cnt == LONG_CYCLES-1 occur in the same cycle, the fall wins. Outputs are release_pulse and short_click; long_pulse is not issued.
- Reset mid-operation:
  - Assertion immediately zeroes all outputs and state, with no release_pulse.
  - If the button is still held when reset is released, it is treated as a fresh press after the full debounce latency.

## Timing
- Edges are numbered from the first clk edge that samples a new btn_in value: s1 updates at edge 1, s2 at edge 2.
- If the input stays stable, btn_level flips at edge STABLE_CYCLES+2. This is the assert/deassert latency.
- press_pulse and release_pulse are asserted in the same cycle btn_level changes, high for exactly one cycle.
- long_pulse rises LONG_CYCLES cycles after press_pulse. long_hold rises in the same cycle as long_pulse.
- short_click and release_pulse are coincident.
- A bounce shorter than STABLE_CYCLES cycles produces no output change.
- Minimum distinguishable click: STABLE_CYCLES cycles high followed by STABLE_CYCLES cycles low.

## Test plan
All scenarios use STABLE_CYCLES=4 and LONG_CYCLES=20.
1. Hold rst=0 with btn_in=1, then release rst.
   - Required: all outputs 0 during reset; btn_level=1 with press_pulse exactly 6 cycles after rst deasserts.
2. Clean press of 10 cycles.
   - Required: press_pulse at edge 6; release_pulse and short_click together 10 cycles later; long_pulse never asserts.
3. Bouncy press: btn_in toggles 1,0,1,0 with 2-cycle intervals, then stays 1.
   - Required: exactly one press_pulse, at edge 6 after the last rising transition; no spurious release_pulse.
4. Hold 30 cycles.
   - Required: long_pulse one cycle, 20 cycles after press_pulse; long_hold high until release; release_pulse with no short_click.
5. Release timed so the debounced fall lands in the same cycle as hold_cnt == 19.
   - Required: release_pulse and short_click; long_pulse never asserts; long_hold never asserts.
6. Assert rst mid-LONG_HELD.
   - Required: long_hold and btn_level drop asynchronously with no release_pulse; after rst deasserts with btn_in=0, all outputs stay 0.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer, debounce filter, and a press FSM
// that produces press/release pulses plus short-click versus long-press classification.
module button_conditioner #(
    parameter logic [31:0] STABLE_CYCLES = 32'd1000000,
    parameter logic [31:0] LONG_CYCLES   = 32'd100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_click,
    output logic long_pulse,
    output logic long_hold
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESSED,
        LONG_HELD
    } state_t;

    state_t      state;
    logic        s1;
    logic        s2;
    logic [31:0] deb_cnt;
    logic [31:0] hold_cnt;
    logic        flip;
    logic        rise;
    logic        fall;

    // The level flips on the cycle the disagreement has lasted STABLE_CYCLES counts.
    assign flip = (s2 != btn_level) && (deb_cnt >= STABLE_CYCLES - 32'd1);
    assign rise = flip && !btn_level;
    assign fall = flip && btn_level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt   <= 32'd0;
            btn_level <= 1'b0;
        end else if (s2 == btn_level) begin
            deb_cnt <= 32'd0;
        end else if (flip) begin
            deb_cnt   <= 32'd0;
            btn_level <= ~btn_level;
        end else begin
            deb_cnt <= deb_cnt + 32'd1;
        end
    end

    // A fall takes priority over reaching the long threshold in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RELEASED;
            hold_cnt      <= 32'd0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_click   <= 1'b0;
            long_pulse    <= 1'b0;
            long_hold     <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_click   <= 1'b0;
            long_pulse    <= 1'b0;
            case (state)
                RELEASED: begin
                    if (rise) begin
                        press_pulse <= 1'b1;
                        hold_cnt    <= 32'd0;
                        state       <= PRESSED;
                    end
                end
                PRESSED: begin
                    if (hold_cnt != 32'hFFFF_FFFF) begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                    if (fall) begin
                        release_pulse <= 1'b1;
                        short_click   <= 1'b1;
                        state         <= RELEASED;
                    end else if (hold_cnt == LONG_CYCLES - 32'd1) begin
                        long_pulse <= 1'b1;
                        long_hold  <= 1'b1;
                        state      <= LONG_HELD;
                    end
                end
                LONG_HELD: begin
                    if (hold_cnt != 32'hFFFF_FFFF) begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                    if (fall) begin
                        release_pulse <= 1'b1;
                        long_hold     <= 1'b0;
                        state         <= RELEASED;
                    end
                end
                default: begin
                    state     <= RELEASED;
                    long_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with STABLE_CYCLES=4 and LONG_CYCLES=20;
// expected output words are hand-derived per clock edge.
module tb_button_conditioner;

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] LVL  = 6'b100000;
    localparam logic [5:0] PRS  = 6'b010000;
    localparam logic [5:0] REL  = 6'b001000;
    localparam logic [5:0] SHT  = 6'b000100;
    localparam logic [5:0] LNG  = 6'b000010;
    localparam logic [5:0] HLD  = 6'b000001;

    typedef struct {
        logic       btn;
        int         cycles;
        logic [5:0] exp;
        string      name;
    } vec_t;

    logic clk;
    logic rst;
    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic short_click;
    logic long_pulse;
    logic long_hold;
    logic [5:0] got;

    vec_t vecs[64];
    int   n_vecs;
    int   checks;
    int   failures;

    button_conditioner #(
        .STABLE_CYCLES(32'd4),
        .LONG_CYCLES  (32'd20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_click  (short_click),
        .long_pulse   (long_pulse),
        .long_hold    (long_hold)
    );

    assign got = {btn_level, press_pulse, release_pulse, short_click, long_pulse, long_hold};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic b, input int n, input logic [5:0] e, input string nm);
        vecs[n_vecs].btn    = b;
        vecs[n_vecs].cycles = n;
        vecs[n_vecs].exp    = e;
        vecs[n_vecs].name   = nm;
        n_vecs++;
    endtask

    task automatic checkOutput(input string nm, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b (level,press,release,short,long,hold) at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Drives btn for n cycles, sampling 1 time unit after each rising edge.
    task automatic applyStimulus(input logic b, input int n, input logic [5:0] exp, input string nm);
        btn_in = b;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checkOutput(nm, exp);
        end
    endtask

    task automatic runVecs(input int first, input int last);
        for (int i = first; i < last; i++) begin
            applyStimulus(vecs[i].btn, vecs[i].cycles, vecs[i].exp, vecs[i].name);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sc1_start, sc2_start, sc3_start, sc4_start, sc4_mid, sc5_start, tbl_end;
        n_vecs   = 0;
        checks   = 0;
        failures = 0;

        sc1_start = n_vecs;
        addVec(1'b1, 5, NONE,             "sc1_wait");
        addVec(1'b1, 1, LVL | PRS,        "sc1_press");
        addVec(1'b1, 2, LVL,              "sc1_held");
        addVec(1'b0, 5, LVL,              "sc1_rel_wait");
        addVec(1'b0, 1, REL | SHT,        "sc1_release");
        addVec(1'b0, 3, NONE,             "sc1_idle");

        sc2_start = n_vecs;
        addVec(1'b1, 5, NONE,             "sc2_wait");
        addVec(1'b1, 1, LVL | PRS,        "sc2_press");
        addVec(1'b1, 4, LVL,              "sc2_held");
        addVec(1'b0, 5, LVL,              "sc2_rel_wait");
        addVec(1'b0, 1, REL | SHT,        "sc2_short_click");
        addVec(1'b0, 3, NONE,             "sc2_idle");

        sc3_start = n_vecs;
        addVec(1'b1, 2, NONE,             "sc3_bounce_hi1");
        addVec(1'b0, 2, NONE,             "sc3_bounce_lo1");
        addVec(1'b1, 2, NONE,             "sc3_bounce_hi2");
        addVec(1'b0, 2, NONE,             "sc3_bounce_lo2");
        addVec(1'b1, 5, NONE,             "sc3_settle");
        addVec(1'b1, 1, LVL | PRS,        "sc3_press");
        addVec(1'b1, 3, LVL,              "sc3_held");
        addVec(1'b0, 5, LVL,              "sc3_rel_wait");
        addVec(1'b0, 1, REL | SHT,        "sc3_release");
        addVec(1'b0, 3, NONE,             "sc3_idle");

        sc4_start = n_vecs;
        addVec(1'b1, 5,  NONE,            "sc4_wait");
        addVec(1'b1, 1,  LVL | PRS,       "sc4_press");
        addVec(1'b1, 19, LVL,             "sc4_pre_long");
        addVec(1'b1, 1,  LVL | LNG | HLD, "sc4_long_pulse");
        addVec(1'b1, 4,  LVL | HLD,       "sc4_long_hold");
        sc4_mid = n_vecs;
        addVec(1'b0, 5,  LVL | HLD,       "sc4_rel_wait");
        addVec(1'b0, 1,  REL,             "sc4_release_no_short");
        addVec(1'b0, 3,  NONE,            "sc4_idle");

        sc5_start = n_vecs;
        addVec(1'b1, 5,  NONE,            "sc5_wait");
        addVec(1'b1, 1,  LVL | PRS,       "sc5_press");
        addVec(1'b1, 14, LVL,             "sc5_held");
        addVec(1'b0, 5,  LVL,             "sc5_rel_wait");
        addVec(1'b0, 1,  REL | SHT,       "sc5_fall_beats_long");
        addVec(1'b0, 3,  NONE,            "sc5_idle");
        tbl_end = n_vecs;

        // Scenario 1: button held through reset.
        rst    = 1'b0;
        btn_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("sc1_in_reset", NONE);
        end
        rst = 1'b1;
        runVecs(sc1_start, sc2_start);

        runVecs(sc2_start, sc3_start);
        runVecs(sc3_start, sc4_start);
        runVecs(sc4_start, sc5_start);
        runVecs(sc5_start, tbl_end);

        // Scenario 6: reset asserted while in LONG_HELD.
        runVecs(sc4_start, sc4_mid);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("sc6_async_reset", NONE);
        btn_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("sc6_in_reset", NONE);
        end
        rst = 1'b1;
        applyStimulus(1'b0, 12, NONE, "sc6_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
